// File: rtl/mips_mem_pkg.sv
// Shared types, constants and helpers for the data-memory responder.
package mips_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // A request fails if it is not word-aligned or its word index is past the end of the RAM.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ({2'b00, addr[31:2]} >= depth_words);
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Word-organised data RAM: synchronous write, combinational read, contents not reset.
module dmem_word_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Store port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  // Load port; sees contents before any write on the same edge.
  assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_bus_responder.sv
// Valid/ready data-memory responder with fixed wait states and a one-cycle response pulse.
module dmem_bus_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             eff_wr_c;
  logic [31:0]      eff_addr_c;
  logic [31:0]      eff_wdata_c;
  logic             eff_err_c;
  logic             ram_we_c;
  logic [31:0]      ram_rdata_c;

  // Request seen at RESP entry: live inputs when leaving IDLE, latched copy when leaving WAIT.
  always_comb begin
    eff_wr_c    = wr_q;
    eff_addr_c  = addr_q;
    eff_wdata_c = wdata_q;
    if (state_q == IDLE) begin
      eff_wr_c    = req_write;
      eff_addr_c  = req_addr;
      eff_wdata_c = req_wdata;
    end
    eff_err_c = addr_err(eff_addr_c, DEPTH_WORDS);
  end

  dmem_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .idx   (eff_addr_c[IDX_W+1:2]),
    .wdata (eff_wdata_c),
    .rdata (ram_rdata_c)
  );

  // Next-state, request capture and response generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ram_we_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Memory access and response fields are resolved on the edge that enters RESP.
    if (state_d == RESP && state_q != RESP) begin
      err_d    = eff_err_c;
      ram_we_c = eff_wr_c && !eff_err_c;
      rdata_d  = (!eff_wr_c && !eff_err_c) ? ram_rdata_c : 32'h0;
    end

    ready_d = (state_d == IDLE);
    valid_d = (state_d == RESP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Randomized bench for two responder builds (LATENCY 2 and LATENCY 0) against a transaction model.
module tb_dmem_bus_responder;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_err;

  int vectors;
  int miscompares;

  logic [31:0] model_mem   [2][DEPTH];
  bit          model_known [2][DEPTH];
  int          lat_of      [2];

  dmem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_l2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid[0]),
    .req_write  (req_write[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .req_ready  (req_ready[0]),
    .resp_valid (resp_valid[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0])
  );

  dmem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_l0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid[1]),
    .req_write  (req_write[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .req_ready  (req_ready[1]),
    .resp_valid (resp_valid[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete transaction on instance inst, checked against the word-array model.
  task automatic run_txn(input int inst, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit scramble);
    int          n;
    int          idx;
    logic        exp_err;
    logic [31:0] exp_rd;
    bit          rd_known;

    exp_err  = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    idx      = exp_err ? 0 : int'(addr / 4);
    rd_known = 1'b1;
    exp_rd   = 32'h0;
    if (!wr && !exp_err) begin
      exp_rd   = model_mem[inst][idx];
      rd_known = model_known[inst][idx];
    end

    @(negedge clk);
    req_valid[inst] = 1'b1;
    req_write[inst] = wr;
    req_addr[inst]  = addr;
    req_wdata[inst] = wdata;
    n = 0;
    while (!req_ready[inst] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[inst]) begin
      check_val("ready_timeout", 32'(req_ready[inst]), 32'h1);
      req_valid[inst] = 1'b0;
      return;
    end

    @(posedge clk);
    #1;
    n = 0;
    while (!resp_valid[inst] && n < 40) begin
      check_val("ready_low_in_wait", 32'(req_ready[inst]), 32'h0);
      if (scramble) begin
        req_valid[inst] = 1'($urandom);
        req_write[inst] = 1'($urandom);
        req_addr[inst]  = $urandom;
        req_wdata[inst] = $urandom;
      end else begin
        req_valid[inst] = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    req_valid[inst] = 1'b0;

    check_val("latency", 32'(n), 32'(lat_of[inst]));
    check_val("resp_err", 32'(resp_err[inst]), 32'(exp_err));
    if (rd_known) check_val("resp_rdata", resp_rdata[inst], exp_rd);
    if (wr && !exp_err) begin
      model_mem[inst][idx]   = wdata;
      model_known[inst][idx] = 1'b1;
    end

    @(posedge clk);
    #1;
    check_val("valid_one_cycle", 32'(resp_valid[inst]), 32'h0);
    check_val("ready_after_resp", 32'(req_ready[inst]), 32'h1);
    check_val("fields_hold_err", 32'(resp_err[inst]), 32'(exp_err));
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    case (sel)
      6:       return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      7:       return 32'h400 + (32'($urandom_range(0, 63)) << 2);
      8:       return {$urandom} & 32'hFFFF_FFFC;
      9:       return 32'h3FC;
      default: return 32'($urandom_range(0, 15)) << 2;
    endcase
  endfunction

  initial begin
    int          n;
    int          first_resp;
    int          cyc;
    logic [31:0] a;

    vectors     = 0;
    miscompares = 0;
    lat_of[0]   = 2;
    lat_of[1]   = 0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < int'(DEPTH); j++) model_known[i][j] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    req_valid = '0;
    req_write = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val("rst_ready", 32'(req_ready[i]), 32'h1);
      check_val("rst_valid", 32'(resp_valid[i]), 32'h0);
      check_val("rst_rdata", resp_rdata[i], 32'h0);
      check_val("rst_err", 32'(resp_err[i]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: store then load, errors, misaligned / out-of-range leave RAM intact.
    run_txn(0, 1'b1, 32'h10, 32'h15, 1'b0);
    run_txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
    run_txn(0, 1'b0, 32'h12, 32'h0, 1'b0);
    run_txn(0, 1'b0, 32'h400, 32'h0, 1'b0);
    run_txn(0, 1'b1, 32'h402, 32'hFFFF_FFFF, 1'b0);
    run_txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
    run_txn(0, 1'b1, 32'h3FC, 32'hCAFE_0001, 1'b0);
    run_txn(0, 1'b0, 32'h3FC, 32'h0, 1'b0);

    // Scrambled inputs during WAIT must not disturb the latched request.
    run_txn(0, 1'b1, 32'h20, 32'h5A5A_0020, 1'b1);
    run_txn(0, 1'b0, 32'h20, 32'h0, 1'b1);

    // Back-to-back: valid held high through RESP; period is LATENCY+2.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h10;
    cyc = 0;
    first_resp = -1;
    n = 0;
    while (n < 2 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (resp_valid[0]) begin
        check_val("b2b_rdata", resp_rdata[0], model_mem[0][4]);
        if (n == 0) first_resp = cyc;
        else check_val("b2b_period", 32'(cyc - first_resp), 32'd4);
        n++;
      end
    end
    req_valid[0] = 1'b0;
    check_val("b2b_count", 32'(n), 32'd2);
    @(posedge clk);

    // LATENCY 0 build.
    run_txn(1, 1'b1, 32'h4, 32'hDEAD_BEEF, 1'b0);
    run_txn(1, 1'b0, 32'h4, 32'h0, 1'b0);
    run_txn(1, 1'b0, 32'h6, 32'h0, 1'b0);

    // Reset during WAIT aborts the store and suppresses the response.
    run_txn(0, 1'b1, 32'h8, 32'hAAAA_5555, 1'b0);
    run_txn(0, 1'b0, 32'h8, 32'h0, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h8;
    req_wdata[0] = 32'h1234;
    n = 0;
    while (!req_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_ready", 32'(req_ready[0]), 32'h1);
    check_val("abort_valid", 32'(resp_valid[0]), 32'h0);
    check_val("abort_rdata", resp_rdata[0], 32'h0);
    check_val("abort_err", 32'(resp_err[0]), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("abort_no_resp", 32'(resp_valid[0]), 32'h0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("abort_no_resp_after", 32'(resp_valid[0]), 32'h0);
    end
    run_txn(0, 1'b0, 32'h8, 32'h0, 1'b0);

    // Randomized traffic on both builds.
    for (int i = 0; i < 40; i++) begin
      for (int inst = 0; inst < 2; inst++) begin
        a = rand_addr();
        run_txn(inst, 1'($urandom), a, $urandom, 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_bus_responder.md
Name: dmem_bus_responder

Overview:
- Target (responder) side of the CPU data-memory interface, replacing the zero-latency combinational data memory behind the multi-cycle/pipelined cores.
- Accepts one word read or write per transaction over a valid/ready request channel.
- Inserts a configurable number of wait states, then returns a single-cycle response carrying read data and an error flag.
- Sits between the core's load/store path and the word-organised data RAM.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, at least 2.
- LATENCY, 2, wait-state cycles between request acceptance and response; range 0..15.
- IDX_W, $clog2(DEPTH_WORDS), word-index width (derived, not overridable).

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  initiator presents a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word-aligned expected.
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse; response fields valid.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On a rising edge with req_valid = 1, the request is accepted: req_write, req_addr and req_wdata are latched.
  - If LATENCY > 0: go to WAIT with counter = LATENCY - 1.
  - If LATENCY = 0: go directly to RESP.
- WAIT:
  - req_ready = 0; req_valid is ignored.
  - Counter decrements each cycle; when counter = 0 on an edge, go to RESP.
- Entry into RESP (same edge that leaves WAIT or IDLE):
  - Error check: err = (addr[1:0] != 0) or (addr[31:2] >= DEPTH_WORDS).
  - Store without error: RAM[addr[IDX_W+1:2]] <= wdata; resp_rdata <= 0.
  - Load without error: resp_rdata <= RAM[idx], reflecting all earlier completed stores.
  - Error: no RAM write; resp_rdata <= 0; resp_err <= 1.
- RESP:
  - resp_valid = 1 for exactly one cycle, req_ready = 0; then return to IDLE.
  - resp_rdata and resp_err hold their values until the next RESP entry.
- Timing: request accepted at edge N gives resp_valid high during cycle N+LATENCY+1. Throughput is one transaction per LATENCY+2 cycles.
- Back-to-back: a request held valid through RESP is accepted in the following IDLE cycle. req_ready is registered (state-decoded), not combinational on req_valid.
- There is no response backpressure; the initiator must capture the response in the resp_valid cycle.
- Reset mid-transaction: the transaction is aborted, no RAM write occurs, and no response is issued.
- Initiator rule: it must hold the request stable until it observes req_ready = 1 at a rising edge.

Decomposition:
- Shared package mips_mem_pkg:
  - FSM state enum (IDLE, WAIT, RESP).
  - Constant WORD_BYTES = 4.
  - Function that returns the misalignment/range error for an address and depth.
- One sub-module: dmem_word_ram (DEPTH_WORDS x 32, synchronous write, combinational read, no reset), instantiated by the responder.

Test Plan:
- Reset, then store addr 0x0000_0010 data 0x0000_0015 with LATENCY = 2 -> resp_valid exactly 3 cycles after accept, resp_err = 0, resp_rdata = 0; a following load from 0x10 returns 0x0000_0015.
- Back-to-back load with req_valid held high through RESP -> accepted on the first IDLE cycle; period is 4 cycles per transaction at LATENCY = 2.
- Load from 0x0000_0012 (misaligned) and from 0x0000_0400 (word 256, out of range) -> resp_err = 1, resp_rdata = 0; the RAM word at 0x10 is unchanged.
- LATENCY = 0 build: store 0x4 = 0xDEAD_BEEF, then load 0x4 -> resp_valid 1 cycle after each accept; load returns 0xDEAD_BEEF.
- Assert rst_n low during WAIT of a store to 0x8 = 0x1234 -> outputs return to reset values immediately, no resp_valid pulse, and a later load of 0x8 returns the prior contents.
- Toggle req_valid and req_addr during WAIT -> ignored; the response reflects the originally latched request.
